pit_table: RTL

- Pending Interest Table sitting directly upstream of the MCU-side SPI block.
- Records interests received from the MCU and forwards new interests to the network side.
- Buffers data packets arriving from the network and, on a prefix match, streams the 32-byte payload into the MCU-side SPI block using its PIT_to_SPI_* handshake; the matched entry is then cleared.

---
 rtl/pit_table.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pit_table.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pit_table: Pending Interest Table that records MCU interests, forwards |
// | new ones, and streams matching 32-byte data payloads to the SPI block. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pit_table #(
  parameter int ENTRIES    = 4,
  parameter int DATA_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SPI_to_PIT_bit,
  input  logic [7:0]  SPI_to_PIT_length,
  input  logic [63:0] SPI_to_PIT_prefix,
  output logic        fwd_valid,
  output logic [7:0]  fwd_length,
  output logic [63:0] fwd_prefix,
  input  logic        net_data_start,
  input  logic [63:0] net_data_prefix,
  input  logic        net_data_valid,
  input  logic [7:0]  net_data_byte,
  output logic        PIT_to_SPI_bit,
  output logic [7:0]  PIT_to_SPI_data,
  output logic [63:0] PIT_to_SPI_prefix,
  output logic        busy,
  output logic        pit_full,
  output logic [7:0]  drop_count
);

  localparam int c_IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int c_BW = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_LOOKUP = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  state_t            r_state;
  logic [ENTRIES-1:0] r_valid;
  logic [7:0]        r_len [ENTRIES];
  logic [63:0]       r_pfx [ENTRIES];
  logic              r_hold_valid;
  logic [7:0]        r_hold_len;
  logic [63:0]       r_hold_pfx;
  logic [63:0]       r_data_pfx;
  logic [c_BW-1:0]   r_cnt;
  logic [7:0]        r_buf [DATA_BYTES];

  logic              w_agg;
  logic              w_has_free;
  logic [c_IW-1:0]   w_free_idx;
  logic              w_lk_hit;
  logic [c_IW-1:0]   w_lk_idx;
  logic              w_process;
  logic              w_insert;
  logic              w_proc_drop;
  logic              w_pulse_drop;
  logic              w_lk_miss;
  logic              w_last;
  logic [c_BW-1:0]   w_next_cnt;
  logic [1:0]        w_drop_inc;
  logic [8:0]        w_drop_sum;

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    w_agg      = 1'b0;
    w_has_free = 1'b0;
    w_free_idx = '0;
    w_lk_hit   = 1'b0;
    w_lk_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_pfx[i] == r_hold_pfx)) w_agg = 1'b1;
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = c_IW'(i);
      end
      if (r_valid[i] && (r_pfx[i] == r_data_pfx)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = c_IW'(i);
      end
    end
  end

  // Holding the interest back during LOOKUP keeps insert and invalidate apart.
  assign w_process    = r_hold_valid && (r_state != S_LOOKUP);
  assign w_insert     = w_process && !w_agg && w_has_free;
  assign w_proc_drop  = w_process && !w_agg && !w_has_free;
  assign w_pulse_drop = SPI_to_PIT_bit && r_hold_valid;
  assign w_lk_miss    = (r_state == S_LOOKUP) && !w_lk_hit;
  assign w_last       = (r_cnt == c_BW'(DATA_BYTES - 1));
  assign w_next_cnt   = r_cnt + 1'b1;
  assign w_drop_inc   = {1'b0, w_pulse_drop} + {1'b0, (w_proc_drop | w_lk_miss)};
  assign w_drop_sum   = {1'b0, drop_count} + {7'd0, w_drop_inc};

  assign busy     = (r_state != S_IDLE);
  assign pit_full = &r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_valid <= 1'b0;
      r_hold_len   <= '0;
      r_hold_pfx   <= '0;
      r_valid      <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_len[i] <= '0;
        r_pfx[i] <= '0;
      end
      fwd_valid    <= 1'b0;
      fwd_length   <= '0;
      fwd_prefix   <= '0;
      drop_count   <= '0;
    end else begin
      if (SPI_to_PIT_bit && !r_hold_valid) begin
        r_hold_valid <= 1'b1;
        r_hold_len   <= SPI_to_PIT_length;
        r_hold_pfx   <= SPI_to_PIT_prefix;
      end else if (w_process) begin
        r_hold_valid <= 1'b0;
      end

      fwd_valid <= w_insert;
      if (w_insert) begin
        r_valid[w_free_idx] <= 1'b1;
        r_len[w_free_idx]   <= r_hold_len;
        r_pfx[w_free_idx]   <= r_hold_pfx;
        fwd_length          <= r_hold_len;
        fwd_prefix          <= r_hold_pfx;
      end

      if ((r_state == S_LOOKUP) && w_lk_hit) r_valid[w_lk_idx] <= 1'b0;

      drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_data_pfx        <= '0;
      r_cnt             <= '0;
      PIT_to_SPI_bit    <= 1'b0;
      PIT_to_SPI_data   <= '0;
      PIT_to_SPI_prefix <= '0;
    end else begin
      PIT_to_SPI_bit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (net_data_start) begin
            r_data_pfx <= net_data_prefix;
            r_cnt      <= '0;
            r_state    <= S_RECV;
          end
        end
        S_RECV: begin
          if (net_data_valid) begin
            r_cnt <= w_last ? '0 : w_next_cnt;
            if (w_last) r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_lk_hit) begin
            PIT_to_SPI_bit    <= 1'b1;
            PIT_to_SPI_data   <= r_buf[0];
            PIT_to_SPI_prefix <= r_data_pfx;
            r_cnt             <= '0;
            r_state           <= S_STREAM;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          // r_cnt tracks the byte currently presented on PIT_to_SPI_data.
          if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt           <= w_next_cnt;
            PIT_to_SPI_data <= r_buf[w_next_cnt];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_RECV) && net_data_valid) r_buf[r_cnt] <= net_data_byte;
  end

endmodule
`default_nettype wire
